// File: rtl/tx_frame_ctrl_pkg.sv
// Shared definitions for the framed ROM serialiser sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding and per-word symbol-count constants.
package tx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Data symbols per word; the ROM word is 4 bits wide.
  localparam int SYM_DATA = 4;

endpackage

// File: rtl/tx_frame_ctrl_baud_tick.sv
// Symbol timer: counts 0..CLK_PER_BIT-1 and flags the last cycle of a symbol.
// Latency: tick is combinational from the registered count.
// Backpressure: none; i_restart holds the count at zero.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_restart  synchronous restart (count forced to 0)
//   o_tick     high on the last cycle of each symbol
module tx_frame_ctrl_baud_tick #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/tx_frame_ctrl.sv
// Sequences ROM word/bit selection and frames each word UART-style on o_tx.
// Latency: first start symbol appears the edge start is accepted; each symbol CLK_PER_BIT cycles.
// Backpressure: start is only accepted in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   i_hit        clock, rising edge        i_clr      async active-low reset
//   i_start      transmit request (level)  i_abort    synchronous abort
//   i_first_nom  first word address        i_last_nom last word address
//   i_le         ROM word at o_nom         i_tx_bit   mux output i_le[o_bit]
//   o_nom        ROM word address          o_bit      mux bit select
//   o_tx         serial line, idle high    o_busy     transfer in progress
//   o_done       one-cycle completion pulse
module tx_frame_ctrl
  import tx_frame_ctrl_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int PARITY_EN   = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic       i_hit,
  input  logic       i_clr,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [3:0] i_first_nom,
  input  logic [3:0] i_last_nom,
  input  logic [3:0] i_le,
  input  logic       i_tx_bit,
  output logic [3:0] o_nom,
  output logic [1:0] o_bit,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_cnt, w_cnt_nxt;      // data index in DATA, stop index in STOP
  logic [3:0] r_nom, w_nom_d;
  logic [1:0] r_bit, w_bit_d;
  logic [3:0] r_last, w_last_d;
  logic       r_tx, w_tx_d;
  logic       r_busy, w_busy_d;
  logic       r_done, w_done_d;
  logic       r_par, w_par_d;

  logic w_tick, w_accept, w_abort, w_last_data, w_last_stop, w_last_word;

  // Symbol timer is held at zero while idle so every symbol after accept is full length.
  tx_frame_ctrl_baud_tick #(.CLK_PER_BIT(CLK_PER_BIT)) u_baud (
    .i_clk     (i_hit),
    .i_rst_n   (i_clr),
    .i_restart (r_state == ST_IDLE),
    .o_tick    (w_tick)
  );

  assign w_accept    = (r_state == ST_IDLE) && i_start && !i_abort;
  assign w_abort     = (r_state != ST_IDLE) && i_abort;
  assign w_last_data = (r_cnt == 2'(SYM_DATA - 1));
  assign w_last_stop = (r_cnt == 2'(STOP_BITS - 1));
  assign w_last_word = (r_nom == r_last);

  // State register
  always_ff @(posedge i_hit or negedge i_clr) begin
    if (!i_clr) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = '0;
        end
        ST_START: if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = '0;
        end
        ST_DATA: if (w_tick) begin
          if (w_last_data) begin
            w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
        ST_PARITY: if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_cnt_nxt   = '0;
        end
        ST_STOP: if (w_tick) begin
          if (w_last_stop) begin
            w_state_nxt = w_last_word ? ST_IDLE : ST_START;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output logic. o_bit runs one symbol ahead of o_tx so the mux output is
  // settled for a whole symbol before it is captured onto the line.
  always_comb begin
    w_tx_d   = r_tx;
    w_nom_d  = r_nom;
    w_bit_d  = r_bit;
    w_last_d = r_last;
    w_par_d  = r_par;
    w_busy_d = r_busy;
    w_done_d = 1'b0;
    if (w_abort) begin
      w_tx_d   = 1'b1;
      w_busy_d = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          w_last_d = i_last_nom;
          w_nom_d  = i_first_nom;
          w_bit_d  = '0;
          w_tx_d   = 1'b0;
          w_par_d  = 1'b0;
          w_busy_d = 1'b1;
        end
        ST_START: if (w_tick) begin
          w_tx_d  = i_tx_bit;
          w_par_d = r_par ^ i_le[r_bit];
          w_bit_d = r_bit + 2'd1;
        end
        ST_DATA: if (w_tick) begin
          if (w_last_data) begin
            // bit already wrapped to 0, ready for the next word
            w_tx_d = (PARITY_EN != 0) ? r_par : 1'b1;
          end else begin
            w_tx_d  = i_tx_bit;
            w_par_d = r_par ^ i_le[r_bit];
            w_bit_d = r_bit + 2'd1;
          end
        end
        ST_PARITY: if (w_tick) begin
          w_tx_d = 1'b1;
        end
        ST_STOP: if (w_tick && w_last_stop) begin
          if (w_last_word) begin
            w_busy_d = 1'b0;
            w_done_d = 1'b1;
          end else begin
            w_nom_d = r_nom + 4'd1;
            w_tx_d  = 1'b0;
            w_par_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_hit or negedge i_clr) begin
    if (!i_clr) begin
      r_tx   <= 1'b1;
      r_nom  <= '0;
      r_bit  <= '0;
      r_last <= '0;
      r_par  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_tx_d;
      r_nom  <= w_nom_d;
      r_bit  <= w_bit_d;
      r_last <= w_last_d;
      r_par  <= w_par_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
    end
  end

  assign o_nom  = r_nom;
  assign o_bit  = r_bit;
  assign o_tx   = r_tx;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Bench for tx_frame_ctrl: expected line symbols, word addresses and transfer
// lengths are queued by the stimulus; per-DUT monitors pop and compare them.
module tb_tx_frame_ctrl;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rom [16];

  // DUT A: parity on, one stop bit
  logic       a_start = 1'b0, a_abort = 1'b0;
  logic [3:0] a_first = '0, a_last = '0;
  logic [3:0] a_nom, a_le;
  logic [1:0] a_bit;
  logic       a_tx, a_busy, a_done, a_txbit;
  // DUT B: no parity, two stop bits
  logic       b_start = 1'b0, b_abort = 1'b0;
  logic [3:0] b_first = '0, b_last = '0;
  logic [3:0] b_nom, b_le;
  logic [1:0] b_bit;
  logic       b_tx, b_busy, b_done, b_txbit;

  assign a_le = rom[a_nom];
  assign a_txbit = a_le[a_bit];
  assign b_le = rom[b_nom];
  assign b_txbit = b_le[b_bit];

  tx_frame_ctrl #(.CLK_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut_a (
    .i_hit(clk), .i_clr(clr), .i_start(a_start), .i_abort(a_abort),
    .i_first_nom(a_first), .i_last_nom(a_last), .i_le(a_le), .i_tx_bit(a_txbit),
    .o_nom(a_nom), .o_bit(a_bit), .o_tx(a_tx), .o_busy(a_busy), .o_done(a_done)
  );

  tx_frame_ctrl #(.CLK_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(2)) dut_b (
    .i_hit(clk), .i_clr(clr), .i_start(b_start), .i_abort(b_abort),
    .i_first_nom(b_first), .i_last_nom(b_last), .i_le(b_le), .i_tx_bit(b_txbit),
    .o_nom(b_nom), .o_bit(b_bit), .o_tx(b_tx), .o_busy(b_busy), .o_done(b_done)
  );

  int checks = 0;
  int errors = 0;

  logic       a_exp_sym[$];
  logic [3:0] a_exp_nom[$];
  int         a_exp_len[$];
  logic       b_exp_sym[$];
  int         b_exp_len[$];
  int         a_cyc = 0, b_cyc = 0, a_done_cnt = 0;
  logic       a_e, b_e;
  logic [3:0] a_en;
  int         a_l, b_l;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [6:0] v, input logic [3:0] n);
    for (int i = 6; i >= 0; i--) begin
      a_exp_sym.push_back(v[i]);
      a_exp_nom.push_back(n);
    end
  endtask

  task automatic push_sym_a(input logic s, input logic [3:0] n);
    a_exp_sym.push_back(s);
    a_exp_nom.push_back(n);
  endtask

  // start, data bits LSB first, even parity, one stop
  function automatic logic [6:0] frame_of(input logic [3:0] w);
    return {1'b0, w[0], w[1], w[2], w[3], ^w, 1'b1};
  endfunction

  // Monitor A: one sample in the middle of each symbol while busy; length on done.
  always @(negedge clk) begin
    if (!clr) begin
      a_cyc = 0;
    end else if (a_busy) begin
      if (a_cyc % CPB == CPB / 2) begin
        if (a_exp_sym.size() == 0) begin
          chk("a_unexpected_symbol", 32'(a_tx), 32'hFFFF_FFFF);
        end else begin
          a_e  = a_exp_sym.pop_front();
          a_en = a_exp_nom.pop_front();
          chk("a_sym", 32'(a_tx), 32'(a_e));
          chk("a_nom", 32'(a_nom), 32'(a_en));
        end
      end
      a_cyc++;
    end else begin
      if (a_done) begin
        a_done_cnt++;
        if (a_exp_len.size() == 0) begin
          chk("a_unexpected_done", 32'(a_cyc), 32'hFFFF_FFFF);
        end else begin
          a_l = a_exp_len.pop_front();
          chk("a_busy_cycles", 32'(a_cyc), 32'(a_l));
        end
      end
      a_cyc = 0;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!clr) begin
      b_cyc = 0;
    end else if (b_busy) begin
      if (b_cyc % CPB == CPB / 2) begin
        if (b_exp_sym.size() == 0) begin
          chk("b_unexpected_symbol", 32'(b_tx), 32'hFFFF_FFFF);
        end else begin
          b_e = b_exp_sym.pop_front();
          chk("b_sym", 32'(b_tx), 32'(b_e));
        end
      end
      b_cyc++;
    end else begin
      if (b_done) begin
        if (b_exp_len.size() == 0) begin
          chk("b_unexpected_done", 32'(b_cyc), 32'hFFFF_FFFF);
        end else begin
          b_l = b_exp_len.pop_front();
          chk("b_busy_cycles", 32'(b_cyc), 32'(b_l));
        end
      end
      b_cyc = 0;
    end
  end

  task automatic start_a(input logic [3:0] f, input logic [3:0] l);
    @(negedge clk);
    a_first = f; a_last = l; a_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input int maxc, input string nm);
    int n = 0;
    while (!a_done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(a_done), 32'd1);
  endtask

  task automatic wait_b_done(input int maxc, input string nm);
    int n = 0;
    while (!b_done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(b_done), 32'd1);
  endtask

  int done_before;

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'h0;
    rom[0]  = 4'b0011;
    rom[1]  = 4'b1000;
    rom[2]  = 4'b0101;
    rom[3]  = 4'b0000;
    rom[5]  = 4'b1011;
    rom[7]  = 4'b1010;
    rom[14] = 4'b0110;
    rom[15] = 4'b1101;

    // reset state
    @(negedge clk);
    chk("rst_tx", 32'(a_tx), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_nom", 32'(a_nom), 32'd0);
    chk("rst_bit", 32'(a_bit), 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // 1: async reset in DATA1 of word 7 (symbols 0, bit0=0, bit1=1 seen first)
    push_sym_a(1'b0, 4'd7);
    push_sym_a(1'b0, 4'd7);
    push_sym_a(1'b1, 4'd7);
    start_a(4'd7, 4'd7);
    repeat (10) @(negedge clk);
    chk("t1_pre_bit", 32'(a_bit), 32'd2);
    #1 clr = 1'b0;
    #1;
    chk("t1_tx", 32'(a_tx), 32'd1);
    chk("t1_busy", 32'(a_busy), 32'd0);
    chk("t1_nom", 32'(a_nom), 32'd0);
    chk("t1_bit", 32'(a_bit), 32'd0);
    chk("t1_done", 32'(a_done), 32'd0);
    @(negedge clk);
    clr = 1'b1;

    // 2: single word 5, le=1011 -> 0,1,1,0,1,1,1 and 28 busy cycles
    push_a(7'b0110111, 4'd5);
    a_exp_len.push_back(28);
    start_a(4'd5, 4'd5);
    wait_a_done(40, "t2_done_seen");
    @(negedge clk);
    chk("t2_done_one_cycle", 32'(a_done), 32'd0);

    // 3: wrap 14,15,0,1; range changes and start pulses while busy are ignored
    push_a(frame_of(rom[14]), 4'd14);
    push_a(frame_of(rom[15]), 4'd15);
    push_a(frame_of(rom[0]), 4'd0);
    push_a(frame_of(rom[1]), 4'd1);
    a_exp_len.push_back(112);
    start_a(4'd14, 4'd1);
    a_first = 4'd3; a_last = 4'd3;
    repeat (20) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_a_done(150, "t3_done_seen");
    repeat (8) @(negedge clk);
    chk("t3_no_extra_frame", 32'(a_busy), 32'd0);

    // 4: abort during DATA1 of the second word; done must never follow
    push_a(frame_of(rom[2]), 4'd2);
    push_sym_a(1'b0, 4'd3);
    push_sym_a(rom[3][0], 4'd3);
    done_before = a_done_cnt;
    start_a(4'd2, 4'd4);
    repeat (37) @(posedge clk);
    @(negedge clk);
    a_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_abort = 1'b0;
    chk("t4_tx", 32'(a_tx), 32'd1);
    chk("t4_busy", 32'(a_busy), 32'd0);
    chk("t4_nom_hold", 32'(a_nom), 32'd3);
    chk("t4_bit_hold", 32'(a_bit), 32'd2);
    repeat (40) @(negedge clk);
    chk("t4_no_done", 32'(a_done_cnt), 32'(done_before));

    // abort in IDLE blocks start
    a_start = 1'b1; a_abort = 1'b1;
    @(negedge clk);
    chk("idle_abort_blocks", 32'(a_busy), 32'd0);
    a_start = 1'b0; a_abort = 1'b0;

    // 5: start held, word 0 repeats; exactly one idle cycle between frames
    for (int k = 0; k < 3; k++) begin
      push_a(frame_of(rom[0]), 4'd0);
      a_exp_len.push_back(28);
    end
    @(negedge clk);
    a_first = 4'd0; a_last = 4'd0; a_start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_a_done(40, "t5_done_seen");
      chk("t5_gap_tx", 32'(a_tx), 32'd1);
      if (k == 2) begin
        a_start = 1'b0;
      end else begin
        @(negedge clk);
        chk("t5_gap_busy", 32'(a_busy), 32'd1);
      end
    end
    repeat (6) @(negedge clk);
    chk("t5_stopped", 32'(a_busy), 32'd0);

    // 6: DUT B, no parity, two stops, le=0000 -> 0,0,0,0,0,1,1
    for (int i = 6; i >= 0; i--) begin
      logic [6:0] v;
      v = 7'b0000011;
      b_exp_sym.push_back(v[i]);
    end
    b_exp_len.push_back(28);
    @(negedge clk);
    b_first = 4'd3; b_last = 4'd3; b_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_start = 1'b0;
    wait_b_done(40, "t6_done_seen");
    repeat (4) @(negedge clk);

    chk("a_sym_queue_empty", 32'(a_exp_sym.size()), 32'd0);
    chk("a_len_queue_empty", 32'(a_exp_len.size()), 32'd0);
    chk("b_sym_queue_empty", 32'(b_exp_sym.size()), 32'd0);
    chk("b_len_queue_empty", 32'(b_exp_len.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
